// File: rtl/seg7_scan.sv
// seg7_scan: eight-digit multiplexed hex display driver; define SEG7_LZB_EN for leading-zero blanking
module seg7_scan #(
   parameter int SCAN_DIV  = 50000,
   parameter int BLANK_CYC = 500
) (
   input  logic        clk,
   input  logic        CLR,
   input  logic [31:0] display,
   input  logic        halt,
   output logic [7:0]  AN,
   output logic [6:0]  SEG,
   output logic        DP,
   output logic        frame_done
);
   localparam int CW = $clog2(SCAN_DIV);
   localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] BLK = CW'(BLANK_CYC);
   logic [CW-1:0] cnt;
   logic [2:0]    idx;
   logic [31:0]   snap;
   logic          armed;
   logic          slot_end;
   logic          wrap;
   logic [31:0]   sh;
   logic [6:0]    hex;
   logic          lit;
   assign slot_end = cnt == LAST;
   assign wrap = slot_end && idx == 3'd7;
   // prescaler, digit index and frame snapshot; armed forces one load right after reset release
   always_ff @(posedge clk or negedge CLR) begin
      if (!CLR) begin
         cnt <= '0;
         idx <= '0;
         snap <= '0;
         armed <= 1'b0;
      end else begin
         cnt <= slot_end ? '0 : cnt + 1'b1;
         idx <= idx + {2'b00, slot_end};
         snap <= (wrap || !armed) ? display : snap;
         armed <= 1'b1;
      end
   end
   // select the current digit's nibble and decide whether the slot is lit
   always_comb begin
      sh = snap >> {idx, 2'b00};
`ifdef SEG7_LZB_EN
      lit = cnt >= BLK && (idx == 3'd0 || sh != 32'd0);
`else
      lit = cnt >= BLK;
`endif
   end
   // active-low hex font
   always_comb begin
      case (sh[3:0])
         4'h0: hex = 7'h40;
         4'h1: hex = 7'h79;
         4'h2: hex = 7'h24;
         4'h3: hex = 7'h30;
         4'h4: hex = 7'h19;
         4'h5: hex = 7'h12;
         4'h6: hex = 7'h02;
         4'h7: hex = 7'h78;
         4'h8: hex = 7'h00;
         4'h9: hex = 7'h10;
         4'hA: hex = 7'h08;
         4'hB: hex = 7'h03;
         4'hC: hex = 7'h46;
         4'hD: hex = 7'h21;
         4'hE: hex = 7'h06;
         default: hex = 7'h0E;
      endcase
   end
   // registered drive of the board pins and the frame pulse
   always_ff @(posedge clk or negedge CLR) begin
      if (!CLR) begin
         AN <= 8'hFF;
         SEG <= 7'h7F;
         DP <= 1'b1;
         frame_done <= 1'b0;
      end else begin
         AN <= lit ? ~(8'd1 << idx) : 8'hFF;
         SEG <= lit ? hex : 7'h7F;
         DP <= !(lit && idx == 3'd0 && halt);
         frame_done <= wrap;
      end
   end
endmodule

// File: tb/tb_seg7_scan.sv
// tb_seg7_scan: directed checks of scan order, blanking, snapshot, halt DP and frame pulse
module tb_seg7_scan;
   logic        clk = 1'b0;
   logic        CLR = 1'b0;
   logic        halt = 1'b0;
   logic [31:0] display = 32'h12345678;
   logic [7:0]  AN;
   logic [6:0]  SEG;
   logic        DP;
   logic        frame_done;
   int checks = 0;
   int errors = 0;
   logic [6:0] fr [6][8];
   logic [7:0] en [6];

   seg7_scan #(.SCAN_DIV(4), .BLANK_CYC(1)) dut (
      .clk(clk), .CLR(CLR), .display(display), .halt(halt),
      .AN(AN), .SEG(SEG), .DP(DP), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // sample n cycles after reset release; fb selects the expected-frame table
   task automatic run(input int n, input int fb);
      for (int k = 1; k <= n; k++) begin
         int p, s, f;
         logic on;
         logic [7:0] ae;
         @(negedge clk);
         p = (k - 1) % 32;
         s = p / 4;
         f = fb + (k - 1) / 32;
         on = (p % 4) != 0 && en[f][s];
         ae = on ? ~(8'd1 << s) : 8'hFF;
         chk($sformatf("AN f%0d k%0d", fb, k), AN, ae);
         chk($sformatf("SEG f%0d k%0d", fb, k), {1'b0, SEG}, on ? {1'b0, fr[f][s]} : 8'h7F);
         chk($sformatf("DP f%0d k%0d", fb, k), {7'd0, DP}, {7'd0, !(halt && ae == 8'hFE)});
         chk($sformatf("FD f%0d k%0d", fb, k), {7'd0, frame_done}, {7'd0, k % 32 == 0});
         if (fb == 0 && k == 14) display = 32'hFFFFFFFF;
         if (fb == 0 && k == 32) halt = 1'b1;
         if (fb == 0 && k == 63) display = 32'h89ABCDEF;
         if (fb == 0 && k == 64) halt = 1'b0;
         if (fb == 4 && k == 20) display = 32'h0;
      end
   endtask

   initial begin
      fr[0] = '{7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79};
      fr[1] = '{default: 7'h0E};
      fr[2] = '{7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00};
      fr[3] = fr[2];
      fr[4] = '{7'h40, 7'h08, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
      fr[5] = '{7'h40, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
      en = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h03, 8'h01};
      repeat (2) @(negedge clk);
      chk("rst AN", AN, 8'hFF);
      chk("rst SEG", {1'b0, SEG}, 8'h7F);
      chk("rst DP", {7'd0, DP}, 8'h01);
      chk("rst FD", {7'd0, frame_done}, 8'h00);
      CLR = 1'b1;
      run(100, 0);
      #2 CLR = 1'b0;
      #1;
      chk("mid AN", AN, 8'hFF);
      chk("mid SEG", {1'b0, SEG}, 8'h7F);
      chk("mid DP", {7'd0, DP}, 8'h01);
      chk("mid FD", {7'd0, frame_done}, 8'h00);
      display = 32'h12345678;
      @(negedge clk);
      CLR = 1'b1;
      run(8, 0);
`ifdef SEG7_LZB_EN
      CLR = 1'b0;
      display = 32'h000000A0;
      @(negedge clk);
      CLR = 1'b1;
      run(64, 4);
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
